// File: rtl/dff_match_scoreboard.sv
// Checker stage for a DFF: compares reference and DUT q on enabled cycles and
// keeps per-run statistics (samples, errors, first mismatch index) with a
// latched verdict once the run ends by stop or by sample-count timeout.
module dff_match_scoreboard #(
  parameter int unsigned WIDTH   = 1,
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned TIMEOUT = 100000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             sample_en,
  input  logic [WIDTH-1:0] q_ref,
  input  logic [WIDTH-1:0] q_dut,
  output logic             mismatch,
  output logic [CNT_W-1:0] samples,
  output logic [CNT_W-1:0] errors,
  output logic [CNT_W-1:0] first_err_idx,
  output logic             first_err_valid,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic             pass
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  // A TIMEOUT beyond the saturating counter range can never be reached.
  localparam bit               TMO_EN  = (TIMEOUT != 0) && (64'(TIMEOUT) <= 64'(CNT_MAX));
  localparam logic [CNT_W-1:0] TMO_VAL = CNT_W'(TIMEOUT);

  state_e           state_q, state_d;
  logic             mismatch_q, mismatch_d;
  logic [CNT_W-1:0] samples_q, samples_d;
  logic [CNT_W-1:0] errors_q, errors_d;
  logic [CNT_W-1:0] first_idx_q, first_idx_d;
  logic             first_valid_q, first_valid_d;
  logic             timeout_q, timeout_d;
  logic             tmo_hit;

  // State and statistics registers; reset aborts any run and clears everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      mismatch_q    <= 1'b0;
      samples_q     <= '0;
      errors_q      <= '0;
      first_idx_q   <= '0;
      first_valid_q <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      mismatch_q    <= mismatch_d;
      samples_q     <= samples_d;
      errors_q      <= errors_d;
      first_idx_q   <= first_idx_d;
      first_valid_q <= first_valid_d;
      timeout_q     <= timeout_d;
    end
  end

  // Next-state and statistics update: start wins over everything, sampling only in RUN.
  always_comb begin
    state_d       = state_q;
    mismatch_d    = 1'b0;
    samples_d     = samples_q;
    errors_d      = errors_q;
    first_idx_d   = first_idx_q;
    first_valid_d = first_valid_q;
    timeout_d     = timeout_q;
    tmo_hit       = 1'b0;

    if (start) begin
      state_d       = S_RUN;
      samples_d     = '0;
      errors_d      = '0;
      first_idx_d   = '0;
      first_valid_d = 1'b0;
      timeout_d     = 1'b0;
    end else if (state_q == S_RUN) begin
      if (sample_en) begin
        mismatch_d = (q_ref != q_dut);
        if (samples_q != CNT_MAX) begin
          samples_d = samples_q + CNT_W'(1);
          tmo_hit   = TMO_EN && (samples_d == TMO_VAL);
        end
        if (mismatch_d) begin
          if (errors_q != CNT_MAX) errors_d = errors_q + CNT_W'(1);
          if (!first_valid_q) begin
            first_idx_d   = samples_q;
            first_valid_d = 1'b1;
          end
        end
      end
      if (stop || tmo_hit) state_d = S_DONE;
      if (tmo_hit) timeout_d = 1'b1;
    end
  end

  assign mismatch        = mismatch_q;
  assign samples         = samples_q;
  assign errors          = errors_q;
  assign first_err_idx   = first_idx_q;
  assign first_err_valid = first_valid_q;
  assign busy            = (state_q == S_RUN);
  assign done            = (state_q == S_DONE);
  assign timeout         = timeout_q;
  assign pass            = (state_q == S_DONE) && (errors_q == '0);

endmodule

// File: tb/tb_dff_match_scoreboard.sv
// Randomized plus directed bench for dff_match_scoreboard. Two instances share
// stimulus: A (CNT_W=8, TIMEOUT=16) and B (CNT_W=4, no timeout, saturation).
module tb_dff_match_scoreboard;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, stop, sample_en;
  logic [3:0] q_ref, q_dut;

  logic       a_mis, a_fv, a_busy, a_done, a_tmo, a_pass;
  logic [7:0] a_smp, a_err, a_idx;
  logic       b_mis, b_fv, b_busy, b_done, b_tmo, b_pass;
  logic [3:0] b_smp, b_err, b_idx;

  int checks = 0;
  int errs   = 0;

  always #5 clk = ~clk;

  dff_match_scoreboard #(.WIDTH(4), .CNT_W(8), .TIMEOUT(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .sample_en(sample_en),
    .q_ref(q_ref), .q_dut(q_dut), .mismatch(a_mis), .samples(a_smp), .errors(a_err),
    .first_err_idx(a_idx), .first_err_valid(a_fv), .busy(a_busy), .done(a_done),
    .timeout(a_tmo), .pass(a_pass)
  );

  dff_match_scoreboard #(.WIDTH(4), .CNT_W(4), .TIMEOUT(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .sample_en(sample_en),
    .q_ref(q_ref), .q_dut(q_dut), .mismatch(b_mis), .samples(b_smp), .errors(b_err),
    .first_err_idx(b_idx), .first_err_valid(b_fv), .busy(b_busy), .done(b_done),
    .timeout(b_tmo), .pass(b_pass)
  );

  // Run-level view of the checker: is a run open, has one finished, and its tallies.
  typedef struct {
    longint samples;
    longint errors;
    longint fidx;
    bit     fvalid;
    bit     mism;
    bit     running;
    bit     finished;
    bit     tmo;
  } mdl_t;

  mdl_t ma, mb;

  function automatic mdl_t mzero();
    mdl_t m;
    m = '{default: 0};
    return m;
  endfunction

  function automatic mdl_t step(mdl_t m, longint cmax, longint tlim,
                                bit st, bit sp, bit en, bit bad);
    mdl_t n;
    n = m;
    n.mism = 1'b0;
    if (st) begin
      n = mzero();
      n.running = 1'b1;
    end else if (m.running) begin
      if (en) begin
        n.mism = bad;
        if (bad && !m.fvalid) begin
          n.fidx   = m.samples;
          n.fvalid = 1'b1;
        end
        if (bad) n.errors = (m.errors + 1 > cmax) ? cmax : m.errors + 1;
        if (m.samples < cmax) begin
          n.samples = m.samples + 1;
          if (tlim != 0 && n.samples == tlim) n.tmo = 1'b1;
        end
      end
      if (sp || n.tmo) begin
        n.running  = 1'b0;
        n.finished = 1'b1;
      end
    end
    return n;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s actual %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic cmp_all();
    chk("a_mismatch", 64'(a_mis),  64'(ma.mism));
    chk("a_samples",  64'(a_smp),  64'(ma.samples));
    chk("a_errors",   64'(a_err),  64'(ma.errors));
    chk("a_fidx",     64'(a_idx),  64'(ma.fidx));
    chk("a_fvalid",   64'(a_fv),   64'(ma.fvalid));
    chk("a_busy",     64'(a_busy), 64'(ma.running));
    chk("a_done",     64'(a_done), 64'(ma.finished));
    chk("a_timeout",  64'(a_tmo),  64'(ma.tmo));
    chk("a_pass",     64'(a_pass), 64'(ma.finished && ma.errors == 0));
    chk("b_mismatch", 64'(b_mis),  64'(mb.mism));
    chk("b_samples",  64'(b_smp),  64'(mb.samples));
    chk("b_errors",   64'(b_err),  64'(mb.errors));
    chk("b_fidx",     64'(b_idx),  64'(mb.fidx));
    chk("b_fvalid",   64'(b_fv),   64'(mb.fvalid));
    chk("b_busy",     64'(b_busy), 64'(mb.running));
    chk("b_done",     64'(b_done), 64'(mb.finished));
    chk("b_timeout",  64'(b_tmo),  64'(mb.tmo));
    chk("b_pass",     64'(b_pass), 64'(mb.finished && mb.errors == 0));
  endtask

  // One clock: advance the model on the edge, compare just after it.
  task automatic cycle();
    bit bad;
    @(posedge clk);
    bad = (q_ref != q_dut);
    if (!rst_n) begin
      ma = mzero();
      mb = mzero();
    end else begin
      ma = step(ma, 255, 16, start, stop, sample_en, bad);
      mb = step(mb, 15, 0, start, stop, sample_en, bad);
    end
    #1;
    cmp_all();
  endtask

  task automatic drive(input bit st, input bit sp, input bit en, input bit bad);
    start     = st;
    stop      = sp;
    sample_en = en;
    q_ref     = 4'($urandom);
    q_dut     = bad ? (q_ref ^ 4'($urandom_range(1, 15))) : q_ref;
    cycle();
  endtask

  task automatic async_reset();
    rst_n = 1'b0;
    #1;
    ma = mzero();
    mb = mzero();
    cmp_all();
    drive(0, 0, 0, 0);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; start = 0; stop = 0; sample_en = 0; q_ref = '0; q_dut = '0;
    ma = mzero(); mb = mzero();
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    chk("rst_samples", 64'(a_smp), 64'd0);
    chk("rst_done", 64'(a_done), 64'd0);
    rst_n = 1'b1;
    drive(0, 0, 1, 1);  // sampling while idle is ignored

    // 1: ten matching samples then stop
    drive(1, 0, 1, 1);  // sample_en during start is ignored
    for (int i = 0; i < 10; i++) drive(0, 0, 1, 0);
    drive(0, 1, 0, 0);
    chk("t1_done", 64'(a_done), 64'd1);
    chk("t1_samples", 64'(a_smp), 64'd10);
    chk("t1_errors", 64'(a_err), 64'd0);
    chk("t1_fvalid", 64'(a_fv), 64'd0);
    chk("t1_pass", 64'(a_pass), 64'd1);
    drive(0, 0, 1, 1);  // ignored in DONE
    chk("t1_hold", 64'(a_smp), 64'd10);

    // 2: mismatches at indices 3 and 7
    drive(1, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, 1, (i == 3) || (i == 7));
      if (i == 3 || i == 7) chk("t2_pulse", 64'(a_mis), 64'd1);
      if (i == 4) chk("t2_pulse_end", 64'(a_mis), 64'd0);
    end
    drive(0, 1, 0, 0);
    chk("t2_errors", 64'(a_err), 64'd2);
    chk("t2_fidx", 64'(a_idx), 64'd3);
    chk("t2_pass", 64'(a_pass), 64'd0);

    // 3: sample_en held high, A times out at 16
    drive(1, 0, 0, 0);
    for (int i = 0; i < 20; i++) drive(0, 0, 1, 0);
    chk("t3_done", 64'(a_done), 64'd1);
    chk("t3_samples", 64'(a_smp), 64'd16);
    chk("t3_timeout", 64'(a_tmo), 64'd1);
    chk("t3_b_sat", 64'(b_smp), 64'd15);

    // 4: stop together with a bad sample
    drive(1, 0, 0, 0);
    drive(0, 1, 1, 1);
    chk("t4_errors", 64'(a_err), 64'd1);
    chk("t4_samples", 64'(a_smp), 64'd1);
    chk("t4_done", 64'(a_done), 64'd1);
    chk("t4_timeout", 64'(a_tmo), 64'd0);

    // 5: 20 mismatches on the 4-bit instance
    drive(1, 0, 0, 0);
    for (int i = 0; i < 20; i++) drive(0, 0, 1, 1);
    drive(0, 1, 0, 0);
    chk("t5_samples", 64'(b_smp), 64'd15);
    chk("t5_errors", 64'(b_err), 64'd15);
    chk("t5_fidx", 64'(b_idx), 64'd0);
    chk("t5_done", 64'(b_done), 64'd1);

    // 6: reset mid-run, new run, restart while running
    drive(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) drive(0, 0, 1, 1);
    chk("t6_pre_err", 64'(a_err), 64'd5);
    #2;
    async_reset();
    chk("t6_rst_err", 64'(a_err), 64'd0);
    chk("t6_rst_busy", 64'(a_busy), 64'd0);
    drive(1, 0, 0, 0);
    chk("t6_new_smp", 64'(a_smp), 64'd0);
    chk("t6_new_busy", 64'(a_busy), 64'd1);
    for (int i = 0; i < 3; i++) drive(0, 0, 1, 1);
    drive(1, 1, 1, 1);  // start beats stop and sample
    chk("t6_rs_smp", 64'(a_smp), 64'd0);
    chk("t6_rs_err", 64'(a_err), 64'd0);
    chk("t6_rs_busy", 64'(a_busy), 64'd1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        #2;
        async_reset();
      end else begin
        drive($urandom_range(0, 29) == 0, $urandom_range(0, 19) == 0,
              $urandom_range(0, 9) < 6, $urandom_range(0, 3) == 0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errs);
    $finish;
  end

endmodule
